// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - FIFO read-mode type and default widths shared by the FIFO family
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int FIFO_DW_DEFAULT = 8;
  localparam int FIFO_AW_DEFAULT = 4;

endpackage

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - sync_fifo write/read/status bundle
// ovf/udf/high_water exist only when SYNC_FIFO_STAT_EN is defined.
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DW = FIFO_DW_DEFAULT,
  parameter int AW = FIFO_AW_DEFAULT
);

  logic          flush;
  logic          wen;
  logic [DW-1:0] wdata;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   af_thresh;
  logic          ren;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic          ralmost_empty;
  logic [AW:0]   ae_thresh;
  logic [AW:0]   count;
`ifdef SYNC_FIFO_STAT_EN
  logic          ovf;
  logic          udf;
  logic [AW:0]   high_water;
`endif

  modport master (
    output flush, wen, wdata, af_thresh, ren, ae_thresh,
    input  wfull, walmost_full, rdata, rempty, ralmost_empty, count
`ifdef SYNC_FIFO_STAT_EN
    , input ovf, udf, high_water
`endif
  );

  modport slave (
    input  flush, wen, wdata, af_thresh, ren, ae_thresh,
    output wfull, walmost_full, rdata, rempty, ralmost_empty, count
`ifdef SYNC_FIFO_STAT_EN
    , output ovf, udf, high_water
`endif
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - DEPTH x DW storage, registered write port, combinational read port
module sync_fifo_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [1 << AW];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy, thresholds, flush and FWFT option
// SYNC_FIFO_STAT_EN adds sticky ovf/udf and a high-water mark.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DW   = FIFO_DW_DEFAULT,
  parameter int AW   = FIFO_AW_DEFAULT,
  parameter int FWFT = 0
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);

  localparam fifo_mode_e  MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  logic [AW:0]   r_wptr, r_rptr, r_count;
  logic [AW:0]   w_count_next;
  logic          r_wfull, r_rempty, r_walmost_full, r_ralmost_empty;
  logic          w_wa, w_ra, w_ram_we;
  logic [DW-1:0] w_ram_rdata;
  logic          w_unused_ptr_msb;

  assign w_wa     = bus.wen && !r_wfull;
  assign w_ra     = bus.ren && !r_rempty;
  assign w_ram_we = w_wa && !bus.flush;

  always_comb begin
    w_count_next = r_count;
    if (w_wa && !w_ra)      w_count_next = r_count + ONE;
    else if (!w_wa && w_ra) w_count_next = r_count - ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_wfull         <= 1'b0;
      r_rempty        <= 1'b1;
      r_walmost_full  <= 1'b0;
      r_ralmost_empty <= 1'b1;
    end else if (bus.flush) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_wfull         <= 1'b0;
      r_rempty        <= 1'b1;
      r_walmost_full  <= 1'b0;
      r_ralmost_empty <= 1'b1;
    end else begin
      if (w_wa) r_wptr <= r_wptr + ONE;
      if (w_ra) r_rptr <= r_rptr + ONE;
      r_count         <= w_count_next;
      r_wfull         <= (w_count_next == DEPTH);
      r_rempty        <= (w_count_next == '0);
      r_walmost_full  <= (w_count_next >= bus.af_thresh);
      r_ralmost_empty <= (w_count_next <= bus.ae_thresh);
    end
  end

  // Pointer MSBs only matter for wrap; fullness comes from the count.
  assign w_unused_ptr_msb = r_wptr[AW] ^ r_rptr[AW];

  sync_fifo_ram #(.DW(DW), .AW(AW)) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (bus.wdata),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

  generate
    if (MODE == FIFO_STD) begin : g_std_read
      logic [DW-1:0] r_rdata;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_rdata <= '0;
        else if (w_ra && !bus.flush) r_rdata <= w_ram_rdata;
      end
      assign bus.rdata = r_rdata;
    end else begin : g_fwft_read
      assign bus.rdata = w_ram_rdata;
    end
  endgenerate

  assign bus.count         = r_count;
  assign bus.wfull         = r_wfull;
  assign bus.rempty        = r_rempty;
  assign bus.walmost_full  = r_walmost_full;
  assign bus.ralmost_empty = r_ralmost_empty;

`ifdef SYNC_FIFO_STAT_EN
  logic        r_ovf, r_udf;
  logic [AW:0] r_high_water;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_high_water <= '0;
    end else if (bus.flush) begin
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_high_water <= '0;
    end else begin
      if (bus.wen && r_wfull)         r_ovf        <= 1'b1;
      if (bus.ren && r_rempty)        r_udf        <= 1'b1;
      if (w_count_next > r_high_water) r_high_water <= w_count_next;
    end
  end

  assign bus.ovf        = r_ovf;
  assign bus.udf        = r_udf;
  assign bus.high_water = r_high_water;
`endif

endmodule
